// File: rtl/tc_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : tc_timer_if
// Description : CPU data-port bundle between the bus master and tc_timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface tc_timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output byteen,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  byteen,
    input  wdata,
    output rdata,
    output irq
  );
endinterface
`default_nettype wire

// File: rtl/tc_timer.sv
`default_nettype none
// ============================================================================
// Module      : tc_timer
// Description : Memory-mapped down-counting timer, one-shot or auto-reload.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic       clk,
  input  logic       reset,
  tc_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        sel_w;
  logic [1:0]  off_w;
  logic        wr_w;
  logic        wr_ctrl_w;
  logic        wr_preset_w;
  logic        en_w;
  logic        im_w;
  logic [1:0]  mode_w;
  logic [31:0] rdata_w;
  logic        unused_addr_lsb;

  assign sel_w       = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off_w       = bus.addr[3:2];
  assign wr_w        = sel_w && (bus.byteen == 4'hF);
  assign wr_ctrl_w   = wr_w && (off_w == 2'd0);
  assign wr_preset_w = wr_w && (off_w == 2'd1);
  assign en_w        = ctrl_q[0];
  assign mode_w      = ctrl_q[2:1];
  assign im_w        = ctrl_q[3];
  assign unused_addr_lsb = &{1'b0, bus.addr[1:0]};

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    // A register write acknowledges a visible interrupt; a masked pending
    // flag survives so that raising IM later still exposes it.
    if ((wr_ctrl_w || wr_preset_w) && im_w) begin
      irq_flag_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (en_w) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_w) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = S_INT;
        end
      end
      S_INT: begin
        if (mode_w == MODE_AUTO) begin
          irq_flag_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes take priority over the FSM clearing EN.
    if (wr_ctrl_w) begin
      ctrl_d = bus.wdata[3:0];
    end
    if (wr_preset_w) begin
      preset_d = bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'h0;
      preset_q   <= 32'h0;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rdata_w = 32'h0;
    if (sel_w) begin
      case (off_w)
        2'd0:    rdata_w = {28'h0, ctrl_q};
        2'd1:    rdata_w = preset_q;
        2'd2:    rdata_w = count_q;
        default: rdata_w = 32'h0;
      endcase
    end
  end

  assign bus.rdata = rdata_w;
  assign bus.irq   = im_w & irq_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tc_timer
// Description : Randomized scenario bench for tc_timer with arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tc_timer;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  tc_timer_if bus ();

  tc_timer #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr   = a;
    bus.wdata  = d;
    bus.byteen = be;
    @(posedge clk);
    #1;
    bus.byteen = 4'h0;
    bus.addr   = 32'h0;
    bus.wdata  = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
    bus.addr = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset      = 1'b1;
    bus.addr   = 32'h0;
    bus.wdata  = 32'h0;
    bus.byteen = 4'h0;
    step();
    step();
    reset = 1'b0;
    rd(A_CTRL, v);
    checks++; if (v !== 32'h0) $display("FAIL reset_ctrl got %h exp 0", v); else passed++;
    rd(A_PRESET, v);
    checks++; if (v !== 32'h0) $display("FAIL reset_preset got %h exp 0", v); else passed++;
    rd(A_COUNT, v);
    checks++; if (v !== 32'h0) $display("FAIL reset_count got %h exp 0", v); else passed++;
    checks++; if (bus.irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", bus.irq); else passed++;
  endtask

  task automatic test_oneshot();
    int n;
    logic [31:0] v, e;
    n = $urandom_range(2, 20);
    wr(A_PRESET, n, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    for (int k = 1; k <= n + 4; k++) begin
      step();
      checks++;
      if (bus.irq !== (k >= n + 2)) $display("FAIL oneshot_irq k=%0d n=%0d got %b exp %b", k, n, bus.irq, (k >= n + 2));
      else passed++;
      if (k >= 2) begin
        e = (k - 2 >= n) ? 32'd0 : n - (k - 2);
        rd(A_COUNT, v);
        checks++; if (v !== e) $display("FAIL oneshot_count k=%0d got %0d exp %0d", k, v, e); else passed++;
      end
    end
    rd(A_CTRL, v);
    checks++; if (v !== 32'h8) $display("FAIL oneshot_ctrl_en_clr got %h exp 8", v); else passed++;
    wr(A_CTRL, 32'h8, 4'hF);
    checks++; if (bus.irq !== 1'b0) $display("FAIL oneshot_ack got %b exp 0", bus.irq); else passed++;
  endtask

  task automatic test_autoreload();
    int n, per, p;
    logic [31:0] v, e;
    logic ei;
    n   = $urandom_range(1, 10);
    per = n + 2;
    wr(A_PRESET, n, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    for (int k = 1; k <= 3 * per + 1; k++) begin
      step();
      ei = (k >= per) && ((k % per) == 0);
      checks++;
      if (bus.irq !== ei) $display("FAIL auto_irq k=%0d n=%0d got %b exp %b", k, n, bus.irq, ei);
      else passed++;
      if (k >= 2) begin
        p = (k - 2) % per;
        e = (p <= n) ? n - p : 32'd0;
        rd(A_COUNT, v);
        checks++; if (v !== e) $display("FAIL auto_count k=%0d got %0d exp %0d", k, v, e); else passed++;
      end
    end
    wr(A_CTRL, 32'h0, 4'hF);
    repeat (4) step();
    checks++; if (bus.irq !== 1'b0) $display("FAIL auto_stop_irq got %b exp 0", bus.irq); else passed++;
  endtask

  task automatic test_masked();
    int n;
    logic [31:0] v;
    n = $urandom_range(1, 8);
    wr(A_CTRL, 32'h1, 4'hF);
    wr(A_PRESET, n, 4'hF);
    for (int k = 2; k <= n + 5; k++) begin
      step();
      checks++; if (bus.irq !== 1'b0) $display("FAIL masked_irq k=%0d got %b exp 0", k, bus.irq); else passed++;
    end
    wr(A_CTRL, 32'h8, 4'hF);
    checks++; if (bus.irq !== 1'b1) $display("FAIL unmask_pending got %b exp 1", bus.irq); else passed++;
    rd(A_CTRL, v);
    checks++; if (v !== 32'h8) $display("FAIL unmask_ctrl got %h exp 8", v); else passed++;
    wr(A_CTRL, 32'h8, 4'hF);
    checks++; if (bus.irq !== 1'b0) $display("FAIL unmask_ack got %b exp 0", bus.irq); else passed++;
  endtask

  task automatic test_bus();
    logic [31:0] v;
    logic [3:0]  be;
    be = 4'($urandom_range(1, 14));
    wr(A_PRESET, 32'h1234_5678, 4'hF);
    wr(A_PRESET, 32'hDEAD_BEEF, be);
    rd(A_PRESET, v);
    checks++; if (v !== 32'h1234_5678) $display("FAIL partial_be be=%h got %h exp 12345678", be, v); else passed++;
    wr(32'h0000_7F14, 32'hCAFE_F00D, 4'hF);
    rd(32'h0000_7F07, v);
    checks++; if (v !== 32'h1234_5678) $display("FAIL unsel_write got %h exp 12345678", v); else passed++;
    wr(A_COUNT, 32'h0000_FFFF, 4'hF);
    rd(A_COUNT, v);
    checks++; if (v !== 32'h0) $display("FAIL count_ro got %h exp 0", v); else passed++;
    rd(A_RSVD, v);
    checks++; if (v !== 32'h0) $display("FAIL rsvd_read got %h exp 0", v); else passed++;
    rd(32'h0000_7F10, v);
    checks++; if (v !== 32'h0) $display("FAIL outside_read got %h exp 0", v); else passed++;
    wr(A_CTRL, 32'hFFFF_FFF0, 4'hF);
    rd(A_CTRL, v);
    checks++; if (v !== 32'h0) $display("FAIL ctrl_upper got %h exp 0", v); else passed++;
  endtask

  task automatic test_pause();
    int n, p2;
    logic [31:0] v;
    n = $urandom_range(12, 30);
    wr(A_PRESET, n, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    repeat (n - 6) step();
    wr(A_CTRL, 32'h8, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      rd(A_COUNT, v);
      checks++; if (v !== 32'd7) $display("FAIL pause_hold i=%0d got %0d exp 7", i, v); else passed++;
    end
    p2 = $urandom_range(12, 20);
    wr(A_PRESET, p2, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    step();
    step();
    rd(A_COUNT, v);
    checks++; if (v !== p2) $display("FAIL pause_reload got %0d exp %0d", v, p2); else passed++;
    step();
    step();
    rd(A_COUNT, v);
    checks++; if (v !== p2 - 2) $display("FAIL pause_run got %0d exp %0d", v, p2 - 2); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.irq !== 1'b0) $display("FAIL midreset_irq got %b exp 0", bus.irq); else passed++;
    rd(A_CTRL, v);
    checks++; if (v !== 32'h0) $display("FAIL midreset_ctrl got %h exp 0", v); else passed++;
    rd(A_PRESET, v);
    checks++; if (v !== 32'h0) $display("FAIL midreset_preset got %h exp 0", v); else passed++;
    rd(A_COUNT, v);
    checks++; if (v !== 32'h0) $display("FAIL midreset_count got %h exp 0", v); else passed++;
  endtask

  task automatic test_zero_preset();
    int n;
    logic [31:0] v, e;
    wr(A_PRESET, 32'h0, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    step();
    step();
    checks++; if (bus.irq !== 1'b0) $display("FAIL zero_early got %b exp 0", bus.irq); else passed++;
    step();
    checks++; if (bus.irq !== 1'b1) $display("FAIL zero_irq got %b exp 1", bus.irq); else passed++;
    n = $urandom_range(10, 20);
    wr(A_PRESET, n, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    repeat (3) step();
    wr(A_PRESET, 32'h2, 4'hF);
    for (int k = 5; k <= n + 3; k++) begin
      step();
      checks++;
      if (bus.irq !== (k >= n + 2)) $display("FAIL midpreset_irq k=%0d n=%0d got %b exp %b", k, n, bus.irq, (k >= n + 2));
      else passed++;
      e = (k - 2 >= n) ? 32'd0 : n - (k - 2);
      rd(A_COUNT, v);
      checks++; if (v !== e) $display("FAIL midpreset_count k=%0d got %0d exp %0d", k, v, e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_masked();
    test_bus();
    test_pause();
    test_zero_preset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
